// File: rtl/pwm_ramp_scheduler.sv
// rtl/pwm_ramp_scheduler.sv - slew-limited per-motor duty scheduler feeding the PWM Avalon bridge
module pwm_ramp_scheduler #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int UPDATE_RATE_HZ   = 1000,
    parameter int DEFAULT_STEP     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic [15:0] pwm_address,
    output logic        pwm_write,
    output logic [31:0] pwm_writedata,
    output logic        busy
);
    localparam int N           = NUMBER_OF_MOTORS;
    localparam int TICK_PERIOD = CLOCK_SPEED_HZ / UPDATE_RATE_HZ;
    localparam int IW          = (N > 1) ? $clog2(N) : 1;
    localparam int TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, ISSUE, ADV} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic            enable_q;
    logic [15:0]     step_q;
    logic [31:0]     target_q  [N];
    logic [31:0]     current_q [N];
    logic [31:0]     readdata_q, readdata_d;
    logic [15:0]     pwm_address_q, pwm_address_d;
    logic [31:0]     pwm_writedata_q, pwm_writedata_d;
    logic            pwm_write_q, pwm_write_d;
    logic            cur_we;
    logic            sel_target, sel_current, sel_step, sel_ctrl;
    logic [31:0]     tgt_cur, cur_cur, next_val;
    logic signed [32:0] diff, mag, step_ext;

    assign sel_target  = (address[15:7] == 9'd0);
    assign sel_current = (address[15:7] == 9'd1);
    assign sel_step    = (address == 16'h0100);
    assign sel_ctrl    = (address == 16'h0101);

    assign tick = (tick_cnt_q == TW'(TICK_PERIOD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // Host owns target[], step and enable; the sweep FSM owns current[].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < N; m++) target_q[m] <= '0;
            step_q   <= 16'(DEFAULT_STEP);
            enable_q <= 1'b0;
        end else if (write) begin
            for (int m = 0; m < N; m++)
                if (sel_target && address[6:0] == 7'(m)) target_q[m] <= writedata;
            if (sel_step) step_q <= writedata[15:0];
            if (sel_ctrl) enable_q <= writedata[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < N; m++) current_q[m] <= '0;
        end else if (cur_we) begin
            for (int m = 0; m < N; m++)
                if (idx_q == IW'(m)) current_q[m] <= next_val;
        end
    end

    // 33-bit difference so opposite-sign extremes cannot wrap.
    always_comb begin
        tgt_cur = '0;
        cur_cur = '0;
        for (int m = 0; m < N; m++) begin
            if (idx_q == IW'(m)) begin
                tgt_cur = target_q[m];
                cur_cur = current_q[m];
            end
        end
        diff     = $signed({tgt_cur[31], tgt_cur}) - $signed({cur_cur[31], cur_cur});
        mag      = diff[32] ? -diff : diff;
        step_ext = $signed({17'd0, step_q});
        if (mag <= step_ext)  next_val = tgt_cur;
        else if (diff[32])    next_val = cur_cur - {16'd0, step_q};
        else                  next_val = cur_cur + {16'd0, step_q};
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        pwm_write_d     = 1'b0;
        pwm_address_d   = pwm_address_q;
        pwm_writedata_d = pwm_writedata_q;
        cur_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q && (tick || pending_q)) begin
                    idx_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (next_val != cur_cur) begin
                    cur_we          = 1'b1;
                    pwm_address_d   = 16'(idx_q);
                    pwm_writedata_d = next_val;
                    pwm_write_d     = 1'b1;
                    state_d         = ISSUE;
                end else begin
                    state_d = ADV;
                end
            end
            ISSUE: state_d = ADV;
            ADV: begin
                if (idx_q == IW'(N - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = EVAL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (write && sel_ctrl && writedata[1]) overrun_d = 1'b0;
        if (!enable_q) begin
            pending_d = 1'b0;
        end else if (state_q == IDLE && state_d == EVAL) begin
            pending_d = 1'b0;
        end else if (tick && state_q != IDLE) begin
            if (pending_q) overrun_d = 1'b1;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            pwm_write_q     <= 1'b0;
            pwm_address_q   <= '0;
            pwm_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            pwm_write_q     <= pwm_write_d;
            pwm_address_q   <= pwm_address_d;
            pwm_writedata_q <= pwm_writedata_d;
        end
    end

    always_comb begin
        readdata_d = '0;
        for (int m = 0; m < N; m++) begin
            if (sel_target && address[6:0] == 7'(m))  readdata_d = target_q[m];
            if (sel_current && address[6:0] == 7'(m)) readdata_d = current_q[m];
        end
        if (sel_step) readdata_d = {16'd0, step_q};
        if (sel_ctrl) readdata_d = {30'd0, overrun_q, enable_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (read) begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata      = readdata_q;
    assign pwm_address   = pwm_address_q;
    assign pwm_write     = pwm_write_q;
    assign pwm_writedata = pwm_writedata_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// tb/tb_pwm_ramp_scheduler.sv - self-checking bench for pwm_ramp_scheduler
module tb_pwm_ramp_scheduler;
    localparam int N = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic [15:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata2, pwm_writedata, pwm_writedata2;
    logic [15:0] pwm_address, pwm_address2;
    logic        pwm_write, pwm_write2, busy, busy2;

    always #5 clock = ~clock;

    pwm_ramp_scheduler #(.NUMBER_OF_MOTORS(N), .CLOCK_SPEED_HZ(50_000_000),
                         .UPDATE_RATE_HZ(500_000), .DEFAULT_STEP(16)) dut (
        .clock(clock), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .pwm_address(pwm_address), .pwm_write(pwm_write),
        .pwm_writedata(pwm_writedata), .busy(busy));

    // Tick period of 10 cycles is shorter than a full 6-motor sweep.
    pwm_ramp_scheduler #(.NUMBER_OF_MOTORS(N), .CLOCK_SPEED_HZ(50_000_000),
                         .UPDATE_RATE_HZ(5_000_000), .DEFAULT_STEP(16)) dut_fast (
        .clock(clock), .reset(reset2), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata2),
        .pwm_address(pwm_address2), .pwm_write(pwm_write2),
        .pwm_writedata(pwm_writedata2), .busy(busy2));

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; string name; } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    wr_t obs[$];
    int  obs_t[$];
    wr_t exp_q[$];
    vec_t tbl[$];
    int  fast_writes = 0;
    logic [15:0] fast_first_addr = 16'hFFFF;
    logic [31:0] fast_first_data = '1;
    longint m_tgt[N];
    longint m_cur[N];
    longint m_step;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pwm_write) begin
            obs.push_back('{int'(pwm_address), pwm_writedata});
            obs_t.push_back(cyc);
        end
        if (pwm_write2) begin
            if (fast_writes == 0) begin
                fast_first_addr = pwm_address2;
                fast_first_data = pwm_writedata2;
            end
            fast_writes++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clock);
        address = a; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        bus_write(a, d);
        if (a < 16'(N)) m_tgt[a] = longint'($signed(d));
        if (a == 16'h0100) m_step = longint'(d[15:0]);
    endtask

    // Reference: one sweep applied to every motor with plain integer arithmetic.
    function automatic void model_sweep();
        exp_q.delete();
        for (int m = 0; m < N; m++) begin
            longint d, mag, nxt;
            d   = m_tgt[m] - m_cur[m];
            mag = (d < 0) ? -d : d;
            if (mag <= m_step) nxt = m_tgt[m];
            else if (d > 0)    nxt = m_cur[m] + m_step;
            else               nxt = m_cur[m] - m_step;
            if (nxt != m_cur[m]) begin
                exp_q.push_back('{m, 32'(nxt)});
                m_cur[m] = nxt;
            end
        end
    endfunction

    function automatic logic [31:0] obs_data(input int i);
        if (i < obs.size()) return obs[i].data;
        return 32'hxxxxxxxx;
    endfunction

    function automatic logic gaps_ok();
        for (int i = 1; i < obs_t.size(); i++)
            if (obs_t[i] - obs_t[i-1] != 3) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n = 0;
        while (busy !== lvl && n < bound) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (busy !== lvl) begin
            bad++;
            $display("FAIL %s: busy=%b after %0d cycles, wanted %b", name, busy, n, lvl);
        end
    endtask

    task automatic sweep_check(input string name);
        model_sweep();
        obs.delete();
        obs_t.delete();
        wait_busy(1'b1, 300, {name, " start"});
        wait_busy(1'b0, 100, {name, " end"});
        check({name, " count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), obs[i].addr, exp_q[i].addr);
            check($sformatf("%s data[%0d]", name, i), obs[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int mode;
        logic found;

        for (int m = 0; m < N; m++) begin
            m_tgt[m] = 0;
            m_cur[m] = 0;
        end
        m_step = 16;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset pwm_write", pwm_write, 0);
        check("reset pwm_address", pwm_address, 0);
        check("reset pwm_writedata", pwm_writedata, 0);
        check("reset readdata", readdata, 0);

        tbl.push_back('{1'b0, 16'h0100, 32'd16,        "step default"});
        tbl.push_back('{1'b0, 16'h0101, 32'd0,         "ctrl default"});
        tbl.push_back('{1'b0, 16'h0000, 32'd0,         "target0 default"});
        tbl.push_back('{1'b1, 16'h0003, 32'hDEADBEEF,  ""});
        tbl.push_back('{1'b0, 16'h0003, 32'hDEADBEEF,  "target3 readback"});
        tbl.push_back('{1'b1, 16'h0100, 32'hABCD0020,  ""});
        tbl.push_back('{1'b0, 16'h0100, 32'h00000020,  "step upper ignored"});
        tbl.push_back('{1'b1, 16'h0083, 32'd5,         ""});
        tbl.push_back('{1'b0, 16'h0083, 32'd0,         "current read-only"});
        tbl.push_back('{1'b1, 16'h0006, 32'd7,         ""});
        tbl.push_back('{1'b0, 16'h0006, 32'd0,         "unmapped target6"});
        tbl.push_back('{1'b0, 16'h0086, 32'd0,         "unmapped current6"});
        tbl.push_back('{1'b0, 16'h0200, 32'd0,         "unmapped 0x200"});
        tbl.push_back('{1'b1, 16'h0101, 32'd2,         ""});
        tbl.push_back('{1'b0, 16'h0101, 32'd0,         "ctrl after clear"});
        tbl.push_back('{1'b1, 16'h0003, 32'd0,         ""});
        tbl.push_back('{1'b1, 16'h0100, 32'd16,        ""});
        tbl.push_back('{1'b0, 16'h0100, 32'd16,        "step restored"});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                host_write(tbl[i].addr, tbl[i].data);
            end else begin
                bus_read(tbl[i].addr, rd);
                check(tbl[i].name, rd, tbl[i].data);
            end
        end

        obs.delete();
        repeat (1000) @(negedge clock);
        check("disabled no writes", obs.size(), 0);

        host_write(16'h0002, 32'd40);
        host_write(16'h0000, 32'd40);
        host_write(16'h0101, 32'd1);
        sweep_check("ramp1");
        check("ramp1 motor2", obs_data(1), 32'd16);
        sweep_check("ramp2");
        check("ramp2 motor2", obs_data(1), 32'd32);
        sweep_check("ramp3");
        check("ramp3 motor2", obs_data(1), 32'd40);
        sweep_check("ramp4");
        check("ramp4 no writes", obs.size(), 0);
        bus_read(16'h0082, rd);
        check("current2", rd, 32'd40);

        host_write(16'h0100, 32'd100);
        host_write(16'h0000, 32'hFFFFFFFB);
        sweep_check("neg");
        check("neg single write", obs.size(), 1);
        check("neg data", obs_data(0), 32'hFFFFFFFB);

        host_write(16'h0100, 32'd0);
        host_write(16'h0003, 32'd500);
        sweep_check("step0");
        check("step0 no writes", obs.size(), 0);

        host_write(16'h0100, 32'd16);
        for (int m = 0; m < N; m++) host_write(16'(m), 32'd1000);
        for (int s = 0; s < 3; s++) begin
            sweep_check($sformatf("all%0d", s));
            check($sformatf("all%0d back-to-back", s), gaps_ok(), 1'b1);
        end

        host_write(16'h0100, 32'h0000FFFF);
        host_write(16'h0000, 32'h7FFFFFFF);
        host_write(16'h0001, 32'h80000000);
        sweep_check("ext_neg0");
        sweep_check("ext_neg1");
        host_write(16'h0001, 32'h7FFFFFFF);
        sweep_check("ext_pos0");
        sweep_check("ext_pos1");
        bus_read(16'h0081, rd);
        check("ext current1", rd, 32'(m_cur[1]));

        for (int r = 0; r < 12; r++) begin
            for (int m = 0; m < N; m++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0)
                    host_write(16'(m), $urandom);
                else if (mode == 1)
                    host_write(16'(m), 32'(m_cur[m] + longint'($urandom_range(0, 800)) - 400));
            end
            if ($urandom_range(0, 3) == 0) host_write(16'h0100, 32'h0000FFFF);
            else                           host_write(16'h0100, 32'($urandom_range(0, 500)));
            sweep_check($sformatf("rand%0d", r));
        end
        for (int m = 0; m < N; m++) begin
            bus_read(16'h0080 + 16'(m), rd);
            check($sformatf("final current%0d", m), rd, 32'(m_cur[m]));
        end

        @(negedge clock);
        reset2 = 1'b0;
        for (int m = 0; m < N; m++) bus_write(16'(m), 32'h40000000);
        bus_write(16'h0100, 32'd16);
        bus_write(16'h0101, 32'd1);
        repeat (100) @(negedge clock);
        bus_read(16'h0101, rd);
        check("overrun set", readdata2, 32'd3);
        check("fast first addr", fast_first_addr, 16'd0);
        check("fast first data", fast_first_data, 32'd16);
        check("fast wrote", fast_writes > 6, 1'b1);
        bus_write(16'h0101, 32'd0);
        repeat (40) @(negedge clock);
        bus_write(16'h0101, 32'd2);
        bus_read(16'h0101, rd);
        check("overrun cleared", readdata2, 32'd0);

        bus_write(16'h0101, 32'd1);
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clock);
            if (pwm_write && pwm_address == 16'd3) found = 1'b1;
        end
        check("issue motor3 seen", found, 1'b1);
        reset = 1'b1;
        #1;
        check("reset drops pwm_write", pwm_write, 0);
        check("reset busy low", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int m = 0; m < N; m++) begin
            bus_read(16'(m), rd);
            check($sformatf("post-reset target%0d", m), rd, 32'd0);
        end
        bus_read(16'h0100, rd);
        check("post-reset step", rd, 32'd16);
        check("post-reset busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
